// File: rtl/org16_pkg.sv
// ============================================================================
// Module      : org16_pkg
// Description : Shared width and word type for the 16-bit logic-unit blocks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package org16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : org16_pkg

`default_nettype wire

// File: rtl/org16_or2_cell.sv
// ============================================================================
// Module      : org16_or2_cell
// Description : Single-bit two-input OR gate, replicated per bit by org16.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module org16_or2_cell
    import org16_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i | b_i;

endmodule : org16_or2_cell

`default_nettype wire

// File: rtl/org16.sv
// ============================================================================
// Module      : org16
// Description : WIDTH-bit bitwise OR with registered result, valid and reductions.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module org16
    import org16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_any,
    output logic             out_all
);

    logic [WIDTH-1:0] or_w;

    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             any_q, any_d;
    logic             all_q, all_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_or
        org16_or2_cell u_cell (
            .a_i (x[i]),
            .b_i (y[i]),
            .y_o (or_w[i])
        );
    end

    // Operands are only looked at when qualified, so junk on x/y never reaches state.
    always_comb begin
        out_d   = out_q;
        any_d   = any_q;
        all_d   = all_q;
        valid_d = 1'b0;
        if (in_valid) begin
            out_d   = or_w;
            any_d   = |or_w;
            all_d   = &or_w;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            any_q   <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            any_q   <= any_d;
            all_q   <= all_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_any   = any_q;
    assign out_all   = all_q;

endmodule : org16

`default_nettype wire

// File: tb/tb_org16.sv
// ============================================================================
// Module      : tb_org16
// Description : Scoreboard bench for org16 against a behavioural OR model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_org16;
    import org16_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    word_t x, y;
    logic  in_valid;
    word_t out;
    logic  out_valid, out_any, out_all;

    org16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .out_any   (out_any),
        .out_all   (out_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t o;
        logic  v;
        logic  a;
        logic  l;
    } exp_t;

    exp_t  q[$];
    word_t m_out = '0;
    logic  m_any = 1'b0;
    logic  m_all = 1'b0;
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle; the model's view of the outputs after the edge goes to the scoreboard.
    task automatic cycle(input word_t a, input word_t b, input logic v);
        x = a;
        y = b;
        in_valid = v;
        @(posedge clk);
        if (rst_n) begin
            if (v) begin
                m_out = a | b;
                m_any = (m_out != 0);
                m_all = (m_out == {W{1'b1}});
            end
            q.push_back('{m_out, v, m_any, m_all});
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        q.delete();
        m_out = '0;
        m_any = 1'b0;
        m_all = 1'b0;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_any", 32'(out_any), 32'h0);
        chk("rst_all", 32'(out_all), 32'h0);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(out), 32'h0);
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out", 32'(out), 32'(e.o));
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("out_any", 32'(out_any), 32'(e.a));
            chk("out_all", 32'(out_all), 32'(e.l));
        end
    end

    initial begin
        word_t a, b;
        x = '0;
        y = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        cycle(16'h0000, 16'h0000, 1'b1);
        cycle(16'h0000, 16'h0001, 1'b1);
        cycle(16'h0003, 16'h0001, 1'b1);
        cycle(16'h1F80, 16'hF800, 1'b1);
        cycle(16'hFFFF, 16'h0000, 1'b1);
        cycle(16'hAAAA, 16'h5555, 1'b1);
        cycle(16'h1234, 16'h1234, 1'b1);

        cycle(16'h00F0, 16'h0F00, 1'b1);
        cycle(16'hFFFF, 16'hFFFF, 1'b0);
        cycle('x, 'x, 1'b0);
        cycle(16'hFFFF, 16'hFFFF, 1'b0);

        for (int i = 0; i < 4; i++) cycle(word_t'($urandom), word_t'($urandom), 1'b1);

        // Reset asserted mid-cycle while out holds a non-zero result.
        cycle(16'h8001, 16'h0100, 1'b1);
        do_reset(1);

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = word_t'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = a;
                default: b = word_t'($urandom);
            endcase
            cycle(a, b, $urandom_range(0, 3) != 0);
        end

        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_org16

`default_nettype wire
